debug_dump_tx: RTL and testbench

// - Debug-unit dump serializer between the MIPS core and the UART transmitter.
// - On a start pulse, streams to the UART, LSB byte first:
//   - PC (4 bytes);
//   - register file words 0..NB_REGS-1;
//   - data memory words 0..NB_MEM_WORDS-1.
// - Reads the register file and data memory through read-address ports with 1-cycle latency.
// - Total stream: (1+NB_REGS+NB_MEM_WORDS)*4 bytes, i.e. 260 with defaults.

---
 rtl/debug_dump_tx_if.sv | 33 +++
 rtl/debug_dump_tx.sv | 219 +++++++++++++++++++++
 tb/tb_debug_dump_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_dump_tx_if.sv
// Bus bundle between the debug unit core side and the dump serializer.
// The serializer takes the slave modport; the core/UART side takes master.
interface debug_dump_tx_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int NB_REGS         = 32,
    parameter int NB_MEM_WORDS    = 32
);
    localparam int REG_AW = $clog2(NB_REGS);
    localparam int MEM_AW = $clog2(NB_MEM_WORDS);

    logic                       i_start;
    logic [DATA_WIDTH-1:0]      i_pc;
    logic [REG_AW-1:0]          o_reg_addr;
    logic [DATA_WIDTH-1:0]      i_reg_data;
    logic [MEM_AW-1:0]          o_mem_addr;
    logic [DATA_WIDTH-1:0]      i_mem_data;
    logic [DATA_WIDTH_UART-1:0] o_tx_byte;
    logic                       o_tx_signal;
    logic                       i_tx_done;
    logic                       o_busy;
    logic                       o_done;

    modport slave (
        input  i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
        output o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_done
    );

    modport master (
        output i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
        input  o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_done
    );
endinterface

// File: rtl/debug_dump_tx.sv
// Debug dump serializer: streams PC, register file and data memory to the UART, LSB byte first.
// Optional DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte after the last memory byte.
module debug_dump_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int NB_REGS         = 32,
    parameter int NB_MEM_WORDS    = 32
) (
    input logic              i_clock,
    input logic              i_reset,
    debug_dump_tx_if.slave   bus
);
    localparam int REG_AW = $clog2(NB_REGS);
    localparam int MEM_AW = $clog2(NB_MEM_WORDS);
    localparam int WCW    = (REG_AW > MEM_AW) ? REG_AW : MEM_AW;
    localparam int BPW    = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BCW    = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC   = 2'd0,
        SEC_REG  = 2'd1,
        SEC_MEM  = 2'd2,
        SEC_CSUM = 2'd3
    } section_t;

    state_t                     state_q, state_d;
    section_t                   section_q, section_d;
    logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]             word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]      buf_q, buf_d;
    logic [DATA_WIDTH_UART-1:0] tx_byte_q, tx_byte_d;
    logic                       tx_signal_q, tx_signal_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [REG_AW-1:0]          reg_addr_q, reg_addr_d;
    logic [MEM_AW-1:0]          mem_addr_q, mem_addr_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH_UART-1:0] csum_q, csum_d;
`endif

    logic [DATA_WIDTH_UART-1:0] cur_byte_s;
    logic                       last_byte_s;
    logic                       last_word_s;
    logic [WCW-1:0]             word_nxt_s;

    // Byte selection and end-of-word / end-of-section detection.
    always_comb begin
        cur_byte_s  = buf_q[int'(byte_cnt_q) * DATA_WIDTH_UART +: DATA_WIDTH_UART];
        last_byte_s = (byte_cnt_q == BCW'(BPW - 1));
        word_nxt_s  = word_cnt_q + WCW'(1);
        case (section_q)
            SEC_REG: last_word_s = (word_cnt_q == WCW'(NB_REGS - 1));
            SEC_MEM: last_word_s = (word_cnt_q == WCW'(NB_MEM_WORDS - 1));
            default: last_word_s = 1'b1;
        endcase
    end

    // Next-state logic. Read addresses are updated on entry to FETCH so that a
    // registered-read memory has its data ready while the FSM sits in LATCH.
    always_comb begin
        state_d     = state_q;
        section_d   = section_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        buf_d       = buf_q;
        tx_byte_d   = tx_byte_q;
        tx_signal_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    buf_d      = bus.i_pc;
                    section_d  = SEC_PC;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                if (section_q == SEC_MEM) begin
                    buf_d = bus.i_mem_data;
                end else begin
                    buf_d = bus.i_reg_data;
                end
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                tx_byte_d   = cur_byte_s;
                tx_signal_d = 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_d      = csum_q ^ cur_byte_s;
`endif
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                if (section_q == SEC_CSUM) begin
                    state_d = ST_DONE;
                end else
`endif
                if (!last_byte_s) begin
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    state_d    = ST_SEND;
                end else if (!last_word_s) begin
                    word_cnt_d = word_nxt_s;
                    if (section_q == SEC_MEM) begin
                        mem_addr_d = MEM_AW'(word_nxt_s);
                    end else begin
                        reg_addr_d = REG_AW'(word_nxt_s);
                    end
                    state_d = ST_FETCH;
                end else begin
                    word_cnt_d = '0;
                    case (section_q)
                        SEC_PC: begin
                            section_d  = SEC_REG;
                            reg_addr_d = '0;
                            state_d    = ST_FETCH;
                        end
                        SEC_REG: begin
                            section_d  = SEC_MEM;
                            mem_addr_d = '0;
                            state_d    = ST_FETCH;
                        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        SEC_MEM: begin
                            section_d  = SEC_CSUM;
                            buf_d      = DATA_WIDTH'(csum_q);
                            byte_cnt_d = '0;
                            state_d    = ST_SEND;
                        end
`endif
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; async reset aborts any dump in progress.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            section_q   <= SEC_PC;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            buf_q       <= '0;
            tx_byte_q   <= '0;
            tx_signal_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_addr_q  <= '0;
            mem_addr_q  <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            section_q   <= section_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            buf_q       <= buf_d;
            tx_byte_q   <= tx_byte_d;
            tx_signal_q <= tx_signal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.o_tx_byte   = tx_byte_q;
    assign bus.o_tx_signal = tx_signal_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_reg_addr  = reg_addr_q;
    assign bus.o_mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected bytes are queued at start and
// popped on every o_tx_signal; UART answers i_tx_done 3 cycles after each byte.
module tb_debug_dump_tx;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int NR = 32;
    localparam int NM = 32;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int EXP_BYTES = (1 + NR + NM) * 4 + 1;
`else
    localparam int EXP_BYTES = (1 + NR + NM) * 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_dump_tx_if #(.DATA_WIDTH(DW), .DATA_WIDTH_UART(UW), .NB_REGS(NR), .NB_MEM_WORDS(NM)) bus ();

    debug_dump_tx #(.DATA_WIDTH(DW), .DATA_WIDTH_UART(UW), .NB_REGS(NR), .NB_MEM_WORDS(NM)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    logic [31:0] regs [NR];
    logic [31:0] mems [NM];
    logic [7:0]  exp_q [$];
    logic [7:0]  stream [0:2047];
    int          total = 0;
    int          bad = 0;
    int          byte_idx = 0;
    int          done_cnt = 0;
    int          pushed = 0;
    bit          hold = 1'b0;

    // Registered-read register file and data memory.
    always @(posedge clk) begin
        bus.i_reg_data <= regs[bus.o_reg_addr];
        bus.i_mem_data <= mems[bus.o_mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build the expected stream from the bench's own copy of PC/regs/mem.
    task automatic push_dump(input logic [31:0] pc);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  x;
        x = 8'h00;
        for (int i = 0; i < 1 + NR + NM; i++) begin
            if (i == 0) w = pc;
            else if (i <= NR) w = regs[i - 1];
            else w = mems[i - 1 - NR];
            for (int k = 0; k < 4; k++) begin
                b = 8'(w >> (8 * k));
                exp_q.push_back(b);
                x = x ^ b;
                pushed++;
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
        pushed++;
`endif
    endtask

    // Output monitor and scoreboard comparison.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.o_tx_signal === 1'b1) begin
                if (byte_idx < 2048) stream[byte_idx] = bus.o_tx_byte;
                if (exp_q.size() == 0) begin
                    check_val("extra_byte", byte_idx + 1, pushed);
                end else begin
                    e = exp_q.pop_front();
                    check_val("stream_byte", {24'h0, bus.o_tx_byte}, {24'h0, e});
                end
                byte_idx++;
            end
            if (bus.o_done === 1'b1) done_cnt++;
        end
    end

    // UART model: done pulse 3 cycles after each send, stalled while hold is set.
    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_signal === 1'b1) begin
                repeat (3) @(negedge clk);
                while (hold) @(negedge clk);
                bus.i_tx_done = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] pc);
        @(negedge clk);
        bus.i_pc    = pc;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (byte_idx >= n) return;
        end
        check_val("wait_bytes_timeout", byte_idx, n);
    endtask

    task automatic wait_done(input int prev, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (done_cnt > prev) return;
        end
        check_val("wait_done_timeout", done_cnt, prev + 1);
    endtask

    initial begin
        int          base;
        int          d0;
        logic [7:0]  held;

        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_pc    = 32'h0;
        for (int k = 0; k < NR; k++) regs[k] = 32'(k);
        for (int k = 0; k < NM; k++) mems[k] = 32'hA500_0000 | 32'(k);

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_tx_byte",   {24'h0, bus.o_tx_byte}, 32'h0);
        check_val("rst_tx_signal", {31'h0, bus.o_tx_signal}, 32'h0);
        check_val("rst_busy",      {31'h0, bus.o_busy}, 32'h0);
        check_val("rst_done",      {31'h0, bus.o_done}, 32'h0);
        check_val("rst_reg_addr",  {27'h0, bus.o_reg_addr}, 32'h0);
        check_val("rst_mem_addr",  {27'h0, bus.o_mem_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full dump with reg[k]=k, mem[k]=A5000000|k.
        base = byte_idx;
        d0   = done_cnt;
        push_dump(32'h0000_0024);
        pulse_start(32'h0000_0024);
        #1;
        check_val("busy_after_start", {31'h0, bus.o_busy}, 32'h1);
        wait_done(d0, 6000);
        check_val("full_count", byte_idx - base, EXP_BYTES);
        check_val("full_busy_clear", {31'h0, bus.o_busy}, 32'h0);
        check_val("full_b0", {24'h0, stream[base + 0]}, 32'h24);
        check_val("full_b1", {24'h0, stream[base + 1]}, 32'h00);
        check_val("full_b4", {24'h0, stream[base + 4]}, 32'h00);
        check_val("full_b8", {24'h0, stream[base + 8]}, 32'h01);
        check_val("full_mem0_b3", {24'h0, stream[base + 4 * (1 + NR) + 3]}, 32'hA5);

        // Back-to-back start, byte order check, start ignored while busy.
        regs[3] = 32'h1122_3344;
        base = byte_idx;
        d0   = done_cnt;
        push_dump(32'h0000_0040);
        pulse_start(32'h0000_0040);
        wait_bytes(base + 10, 200);
        pulse_start(32'hDEAD_BEEF);
        wait_done(d0, 6000);
        check_val("b2b_count", byte_idx - base, EXP_BYTES);
        check_val("order_16", {24'h0, stream[base + 16]}, 32'h44);
        check_val("order_17", {24'h0, stream[base + 17]}, 32'h33);
        check_val("order_18", {24'h0, stream[base + 18]}, 32'h22);
        check_val("order_19", {24'h0, stream[base + 19]}, 32'h11);
        repeat (30) @(negedge clk);
        #1;
        check_val("done_pulses", done_cnt, 2);
        check_val("idle_after_ignored_start", {31'h0, bus.o_busy}, 32'h0);

        // Handshake stall: UART withholds i_tx_done for 1000 cycles.
        base = byte_idx;
        d0   = done_cnt;
        push_dump(32'h0000_0100);
        pulse_start(32'h0000_0100);
        wait_bytes(base + 6, 200);
        hold = 1'b1;
        held = bus.o_tx_byte;
        repeat (1000) @(negedge clk);
        #1;
        check_val("stall_no_signal", byte_idx - base, 6);
        check_val("stall_byte_stable", {24'h0, bus.o_tx_byte}, {24'h0, held});
        check_val("stall_busy", {31'h0, bus.o_busy}, 32'h1);
        hold = 1'b0;
        wait_done(d0, 6000);
        check_val("stall_count", byte_idx - base, EXP_BYTES);

        // Async reset in the middle of a dump.
        base = byte_idx;
        d0   = done_cnt;
        push_dump(32'h0000_0200);
        pulse_start(32'h0000_0200);
        wait_bytes(base + 3, 200);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_tx_signal", {31'h0, bus.o_tx_signal}, 32'h0);
        check_val("abort_busy",      {31'h0, bus.o_busy}, 32'h0);
        check_val("abort_reg_addr",  {27'h0, bus.o_reg_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (50) @(negedge clk);
        #1;
        check_val("abort_no_done", done_cnt, d0);
        check_val("abort_no_bytes", byte_idx - base, 3);
        check_val("abort_idle", {31'h0, bus.o_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
